// File: rtl/popcnt_sched_pkg.sv
// Shared types and width helpers for the popcount request scheduler.
package popcnt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } req_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  function automatic int cnt_width(input int w);
    return clog2(w) + 1;
  endfunction

  // Tag index needs at least one bit even for tiny requester counts.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/count_ones.sv
// Pipelined population count: dout is valid LAT cycles after enable/din.
module count_ones
  import popcnt_sched_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LAT   = 1,
  localparam int CW   = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  output logic [CW-1:0]    dout
);

  logic [CW-1:0] pipe_q [LAT];
  logic [CW-1:0] pipe_d [LAT];
  logic [CW-1:0] sum;

  always_comb begin
    sum = '0;
    for (int b = 0; b < WIDTH; b++) begin
      sum = sum + {{(CW-1){1'b0}}, din[b]};
    end
    pipe_d[0] = enable ? sum : '0;
    for (int s = 1; s < LAT; s++) begin
      pipe_d[s] = pipe_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) pipe_q[s] <= '0;
    end else begin
      for (int s = 0; s < LAT; s++) pipe_q[s] <= pipe_d[s];
    end
  end

  assign dout = pipe_q[LAT-1];

endmodule

// File: rtl/popcnt_rr_arb.sv
// Round-robin arbiter: grants the first eligible index at or after ptr, wrapping.
module popcnt_rr_arb
  import popcnt_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW  = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic [IW-1:0]   ptr_next
);

  logic found;
  int   idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    ptr_next  = ptr;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && elig[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
        ptr_next   = IW'((idx + 1) % NREQ);
      end
    end
  end

endmodule

// File: rtl/popcnt_req_sched.sv
// Shares one pipelined count_ones among NREQ requesters with RR issue and tagged return.
// Optional grant counter enabled by defining POPCNT_SCHED_STATS_EN.
module popcnt_req_sched
  import popcnt_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  parameter int LAT   = 1,
  localparam int CW   = cnt_width(WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_vld,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_rdy,
  output logic [NREQ-1:0]       cpl_vld,
  output logic [NREQ*CW-1:0]    cpl_cnt,
  input  logic [NREQ-1:0]       cpl_ack,
  output logic                  busy,
  output logic [31:0]           stat_grants
);

  localparam int IW = idx_width(NREQ);

  req_state_e        state_q [NREQ];
  req_state_e        state_d [NREQ];
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [LAT-1:0]    tag_vld_q, tag_vld_d;
  logic [IW-1:0]     tag_idx_q [LAT];
  logic [IW-1:0]     tag_idx_d [LAT];
  logic [NREQ*CW-1:0] cpl_cnt_q, cpl_cnt_d;

  logic [NREQ-1:0]   elig, grant, not_idle;
  logic [IW-1:0]     grant_idx;
  logic              grant_vld;
  logic [WIDTH-1:0]  pop_din;
  logic [CW-1:0]     pop_dout;
  logic              ret_vld;
  logic [IW-1:0]     ret_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign elig[gi]     = req_vld[gi] && (state_q[gi] == IDLE);
      assign not_idle[gi] = (state_q[gi] != IDLE);
      assign cpl_vld[gi]  = (state_q[gi] == DONE);
    end
  endgenerate

  popcnt_rr_arb #(.NREQ(NREQ)) u_arb (
    .elig      (elig),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .ptr_next  (ptr_d)
  );

  assign grant_vld = |grant;
  assign req_rdy   = grant;
  assign busy      = |not_idle;

  // One-hot grant selects the launched vector; zero when idle.
  always_comb begin
    pop_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) pop_din = pop_din | req_data[i*WIDTH +: WIDTH];
    end
  end

  count_ones #(.WIDTH(WIDTH), .LAT(LAT)) u_count_ones (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (grant_vld),
    .din    (pop_din),
    .dout   (pop_dout)
  );

  assign ret_vld = tag_vld_q[LAT-1];
  assign ret_idx = tag_idx_q[LAT-1];

  always_comb begin
    tag_vld_d[0] = grant_vld;
    tag_idx_d[0] = grant_idx;
    for (int s = 1; s < LAT; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
    cpl_cnt_d = cpl_cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        IDLE: if (grant[i]) state_d[i] = BUSY;
        BUSY: if (ret_vld && ret_idx == IW'(i)) begin
          state_d[i] = DONE;
          cpl_cnt_d[i*CW +: CW] = pop_dout;
        end
        DONE: if (cpl_ack[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      tag_vld_q <= '0;
      cpl_cnt_q <= '0;
      for (int s = 0; s < LAT; s++) tag_idx_q[s] <= '0;
      for (int i = 0; i < NREQ; i++) state_q[i] <= IDLE;
    end else begin
      ptr_q     <= ptr_d;
      tag_vld_q <= tag_vld_d;
      cpl_cnt_q <= cpl_cnt_d;
      for (int s = 0; s < LAT; s++) tag_idx_q[s] <= tag_idx_d[s];
      for (int i = 0; i < NREQ; i++) state_q[i] <= state_d[i];
    end
  end

  assign cpl_cnt = cpl_cnt_q;

`ifdef POPCNT_SCHED_STATS_EN
  logic [31:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (grant_vld && stat_q != 32'hFFFF_FFFF) stat_d = stat_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign stat_grants = stat_q;
`else
  assign stat_grants = '0;
`endif

endmodule

// File: tb/tb_popcnt_req_sched.sv
// Directed bench for popcnt_req_sched (NREQ=4, WIDTH=16, LAT=1).
module tb_popcnt_req_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 16;
  localparam int LAT   = 1;
  localparam int CW    = 5;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_vld;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_rdy;
  logic [NREQ-1:0]       cpl_vld;
  logic [NREQ*CW-1:0]    cpl_cnt;
  logic [NREQ-1:0]       cpl_ack;
  logic                  busy;
  logic [31:0]           stat_grants;

  int n_vec = 0;
  int n_err = 0;

  popcnt_req_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_vld     (req_vld),
    .req_data    (req_data),
    .req_rdy     (req_rdy),
    .cpl_vld     (cpl_vld),
    .cpl_cnt     (cpl_cnt),
    .cpl_ack     (cpl_ack),
    .busy        (busy),
    .stat_grants (stat_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int i);
    return cpl_cnt[i*CW +: CW];
  endfunction

  task automatic set_data(input int i, input logic [WIDTH-1:0] v);
    req_data[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req_vld  = '0;
    req_data = '0;
    cpl_ack  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [CW-1:0] exp_cnt [4];
    int g0, g2, ng;
    logic [3:0] e_rdy, e_vld;

    exp_cnt[0] = 5'd1; exp_cnt[1] = 5'd8; exp_cnt[2] = 5'd8; exp_cnt[3] = 5'd0;

    // Reset values
    rst_n = 1'b0; req_vld = '0; req_data = '0; cpl_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy",  32'(req_rdy), 32'h0);
    check("rst_cvld", 32'(cpl_vld), 32'h0);
    check("rst_ccnt", 32'(cpl_cnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_stat", stat_grants, 32'h0);
    rst_n = 1'b1;

    // Single all-ones request from requester 0
    req_vld = 4'b0001; set_data(0, 16'hFFFF);
    #1; check("t1_rdy_c0", 32'(req_rdy), 32'h1);
    tick();
    req_vld = '0;
    #1; check("t1_cvld_c1", 32'(cpl_vld), 32'h0);
    check("t1_busy_c1", 32'(busy), 32'h1);
    tick();
    #1; check("t1_cvld_c2", 32'(cpl_vld), 32'h1);
    check("t1_cnt0", 32'(cnt_of(0)), 32'd16);
    cpl_ack = 4'b0001;
    tick();
    cpl_ack = '0;
    #1; check("t1_cvld_ack", 32'(cpl_vld), 32'h0);
    check("t1_busy_ack", 32'(busy), 32'h0);

    // All four requesters at once
    do_reset();
    req_vld = 4'hF;
    set_data(0, 16'h0001); set_data(1, 16'h00FF); set_data(2, 16'h0F0F); set_data(3, 16'h0000);
    for (int c = 0; c < 6; c++) begin
      #1;
      e_rdy = (c < 4) ? 4'(1 << c) : 4'h0;
      e_vld = (c < 2) ? 4'h0 : 4'((1 << (c - 1)) - 1);
      check($sformatf("t2_rdy_c%0d", c), 32'(req_rdy), 32'(e_rdy));
      check($sformatf("t2_cvld_c%0d", c), 32'(cpl_vld), 32'(e_vld));
      if (c >= 2) check($sformatf("t2_cnt%0d", c - 2), 32'(cnt_of(c - 2)), 32'(exp_cnt[c-2]));
      tick();
    end
    req_vld = '0;

    // Requester 1 parked in DONE; 0 and 2 keep flowing
    do_reset();
    req_vld = 4'b0010; set_data(1, 16'h00F0);
    #1; check("t3_rdy1_c0", 32'(req_rdy), 32'h2);
    tick(); tick();
    #1; check("t3_cvld1", 32'(cpl_vld[1]), 32'h1);
    check("t3_cnt1", 32'(cnt_of(1)), 32'd4);
    req_vld = 4'b0111; set_data(0, 16'h0003); set_data(2, 16'h0007);
    g0 = 0; g2 = 0;
    for (int c = 0; c < 12; c++) begin
      cpl_ack = cpl_vld & 4'b0101;
      #1;
      check($sformatf("t3_rdy1_%0d", c), 32'(req_rdy[1]), 32'h0);
      check($sformatf("t3_cnt1_%0d", c), 32'(cnt_of(1)), 32'd4);
      g0 += int'(req_rdy[0]);
      g2 += int'(req_rdy[2]);
      tick();
    end
    check("t3_grants0", 32'(g0), 32'd4);
    check("t3_grants2", 32'(g2), 32'd4);
    cpl_ack = '0; req_vld = '0;

    // Fairness: 0 and 2 re-request immediately after ack
    do_reset();
    req_vld = 4'b0101; set_data(0, 16'h8001); set_data(2, 16'hFFFE);
    ng = 0;
    for (int c = 0; c < 20; c++) begin
      cpl_ack = cpl_vld;
      #1;
      e_rdy = (c % 3 == 0) ? 4'h1 : (c % 3 == 1) ? 4'h4 : 4'h0;
      e_vld = (c < 2) ? 4'h0 : (c % 3 == 2) ? 4'h1 : (c % 3 == 0) ? 4'h4 : 4'h0;
      check($sformatf("t4_rdy_c%0d", c), 32'(req_rdy), 32'(e_rdy));
      check($sformatf("t4_cvld_c%0d", c), 32'(cpl_vld), 32'(e_vld));
      if (c % 3 == 2) check($sformatf("t4_cnt0_c%0d", c), 32'(cnt_of(0)), 32'd2);
      if (c >= 3 && c % 3 == 0) check($sformatf("t4_cnt2_c%0d", c), 32'(cnt_of(2)), 32'd15);
      if (req_rdy != '0) begin
        ng++;
        $display("grant cycle=%0d rdy=%b", c, req_rdy);
      end
      tick();
    end
    check("t4_ngrants", 32'(ng), 32'd14);
    cpl_ack = '0; req_vld = '0;

    // Reset mid-operation
    do_reset();
    req_vld = 4'b1001; set_data(0, 16'hFFFF); set_data(3, 16'hFFFF);
    #1; check("t5_rdy_c0", 32'(req_rdy), 32'h1);
    tick();
    #1; check("t5_rdy_c1", 32'(req_rdy), 32'h8);
    rst_n = 1'b0; req_vld = '0;
    #1;
    check("t5_rst_rdy",  32'(req_rdy), 32'h0);
    check("t5_rst_cvld", 32'(cpl_vld), 32'h0);
    check("t5_rst_ccnt", 32'(cpl_cnt), 32'h0);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_stat", stat_grants, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("t5_post_cvld%0d", c), 32'(cpl_vld), 32'h0);
      check($sformatf("t5_post_busy%0d", c), 32'(busy), 32'h0);
      tick();
    end
    req_vld = 4'b1000; set_data(3, 16'h0101);
    #1; check("t5_new_rdy", 32'(req_rdy), 32'h8);
    tick();
    req_vld = '0;
    tick();
    #1; check("t5_new_cvld", 32'(cpl_vld), 32'h8);
    check("t5_new_cnt3", 32'(cnt_of(3)), 32'd2);
    cpl_ack = 4'b1000;
    tick();
    cpl_ack = '0;

    // Grant counter
    do_reset();
    #1; check("t6_stat0", stat_grants, 32'h0);
    for (int k = 0; k < 10; k++) begin
      req_vld = 4'b0001; set_data(0, 16'(k));
      tick();
      req_vld = '0;
      tick();
      cpl_ack = 4'b0001;
      tick();
      cpl_ack = '0;
    end
    #1;
`ifdef POPCNT_SCHED_STATS_EN
    check("t6_stat10", stat_grants, 32'd10);
`else
    check("t6_stat_off", stat_grants, 32'd0);
`endif
    check("t6_cnt0_last", 32'(cnt_of(0)), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/popcnt_req_sched.md
Name: popcnt_req_sched

Overview:
- Round-robin scheduler that shares one pipelined popcount unit (`count_ones`) among NREQ requesters in the req/cpl subsystem.
- Accepts one bit-vector per requester over a valid/ready handshake and launches at most one vector per cycle into the shared unit.
- Tags each launch so the returning count is routed to the originating requester, where it is held until that requester acknowledges it.
- Each requester has a credit of exactly one outstanding request.

Parameters:
- NREQ, 4: number of requesters, 2..16.
- WIDTH, 16: vector width, power of 2, ≥2.
- LAT, 1: cycles from `enable`/`din` to valid `dout` of the shared `count_ones` instance (≥1).
  - Must equal that instance's configured latency.
- CW, log2(WIDTH)+1: count width (localparam, derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_vld  in  NREQ  per-requester request valid.
- req_data  in  NREQ*WIDTH  request vectors; requester i uses bits [i*WIDTH +: WIDTH].
- req_rdy  out  NREQ  one-hot grant; a transfer occurs when req_vld[i] & req_rdy[i].
- cpl_vld  out  NREQ  result held for requester i.
- cpl_cnt  out  NREQ*CW  counts; requester i uses bits [i*CW +: CW].
- cpl_ack  in  NREQ  requester i consumes its result.
- busy  out  1  any requester in BUSY or DONE.
- stat_grants  out  32  grant counter (see Optional Feature).

Interface rule (already decided): reset rst_n, asynchronous, active-low; clock clk.

Behaviour:
- Per-requester FSM, states IDLE, BUSY, DONE:
  - IDLE→BUSY on grant.
  - BUSY→DONE when the tagged result returns.
  - DONE→IDLE on cpl_ack[i].
- req_rdy is combinational from registered state and the RR pointer.
  - Eligible set = req_vld & (state==IDLE).
  - Grant goes to the first eligible index at or after the pointer, wrapping modulo NREQ.
  - At most one grant per cycle; no grant if the eligible set is empty.
- RR pointer:
  - Resets to 0.
  - After a grant to i, it becomes (i+1) mod NREQ.
  - Unchanged when there is no grant.
- Issue path:
  - Granted vector drives the shared unit's din.
  - enable=1 in the grant cycle only; din=0 and enable=0 otherwise.
- Tag pipe:
  - LAT-deep shift register of {valid, index}, aligned with the shared unit's output.
  - On valid tag exit, dout[CW-1:0] is registered into cpl_cnt[idx] and state[idx] becomes DONE.
- Latency: grant in cycle T → cpl_vld[i] high from cycle T+LAT+1.
- Result holding: cpl_cnt[i] is stable while DONE.
- Acknowledge:
  - cpl_ack[i] in DONE deasserts cpl_vld[i] the next cycle.
  - Earliest re-grant to i is the cycle after ack, since eligibility uses registered state.
  - cpl_ack[i] while not in DONE is ignored.
- Boundary values:
  - All-zero vector: cpl_cnt=0 with cpl_vld=1.
  - All-ones vector: cpl_cnt=WIDTH.
- Simultaneous events:
  - Completion for i and grant to j≠i in the same cycle are both honoured.
  - A completion and a grant can never target the same i.
- busy = OR over requesters of (state≠IDLE).
- Reset values: req_rdy=0, cpl_vld=0, cpl_cnt=0, busy=0, stat_grants=0, pointer=0, all FSMs IDLE, tag valids=0.
- Reset mid-operation discards all in-flight tags; no completion is produced after release.

Optional Feature:
- Macro: POPCNT_SCHED_STATS_EN.
- Defined: stat_grants increments by 1 on each grant and saturates at 32'hFFFF_FFFF; it is not cleared by cpl_ack.
- Undefined: no counter logic; stat_grants is tied to 0.

Decomposition:
- Package popcnt_sched_pkg holds:
  - State enum IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - A clog2 function.
  - A CW helper.
  - Tag index width, clog2(NREQ) with minimum 1.
- Sub-module popcnt_rr_arb: parameterised NREQ round-robin arbiter.
  - Inputs: eligible vector, registered pointer.
  - Outputs: one-hot grant, grant index, next pointer.
- The shared popcount is instantiated inside popcnt_req_sched.

Test Plan (NREQ=4, WIDTH=16, LAT=1):
- Idle from reset: req_vld[0]=1, data 16'hFFFF → req_rdy[0]=1 at cycle 0; cpl_vld[0]=1 at cycle 2 with cpl_cnt0=5'd16; ack → cpl_vld[0]=0 next cycle.
- All req_vld=4'hF from reset, data 16'h0001/16'h00FF/16'h0F0F/16'h0000:
  - grants go to 0,1,2,3 on cycles 0..3;
  - counts 1,8,8,0 appear on cycles 2..5.
- Requester 1 in DONE, never acked, req_vld[1] held 1 → req_rdy[1] stays 0; requesters 0 and 2 continue to be granted; cpl_cnt1 stays stable.
- Requesters 0 and 2 re-request immediately after each ack for 20 cycles → grants alternate 0,2,0,2; neither is starved.
- rst_n low for 1 cycle while requesters 0 and 3 are BUSY → all outputs 0; no cpl_vld after release; a new request completes normally.
- With POPCNT_SCHED_STATS_EN: 10 grants → stat_grants=10. Without the macro: stat_grants=0.
